// File: rtl/operand_serializer_if.sv
// Operand handshake plus serial bit stream between an operand source and the serializer.
// Latency: none; this is a bundle of wires.
// Backpressure: in_ready from the serializer throttles in_valid from the source.
interface operand_serializer_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a_word;
   logic [WIDTH-1:0] b_word;
   logic             cin;
   logic             a_bit;
   logic             b_bit;
   logic             cin_bit;
   logic             frame_start;
   logic             bit_valid;
   logic             last_bit;
   logic [7:0]       frame_count;

   // Operand source / serial consumer side
   modport master (
      output in_valid, a_word, b_word, cin,
      input  in_ready, a_bit, b_bit, cin_bit, frame_start, bit_valid, last_bit, frame_count
   );

   // Serializer side
   modport slave (
      input  in_valid, a_word, b_word, cin,
      output in_ready, a_bit, b_bit, cin_bit, frame_start, bit_valid, last_bit, frame_count
   );
endinterface

// File: rtl/operand_serializer.sv
// Parallel-to-serial operand transmitter for the bit-serial adder, LSB first, frame_start on bit 0.
// Latency: bit 0 appears the cycle after the handshake; frame period WIDTH+GAP+1 (WIDTH when GAP=0, back-to-back).
// Backpressure: in_ready only in IDLE, or on the last bit when GAP=0; forced low while clr is low.
module operand_serializer #(
   parameter int WIDTH = 8,
   parameter int GAP   = 1
) (
   input  logic                 clk,
   input  logic                 clr,
   operand_serializer_if.slave  bus
);
   localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  LAST     = CW'(WIDTH - 1);
   localparam logic [CW-1:0]  PENULT   = CW'(WIDTH - 2);
   localparam logic [3:0]     GAP_LAST = 4'(GAP - 1);
   localparam bit             B2B      = (GAP == 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_GAP
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_sh_q, a_sh_d;
   logic [WIDTH-1:0]  b_sh_q, b_sh_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [3:0]        gap_q, gap_d;
   logic [7:0]        fc_q, fc_d;
   logic              a_bit_q, a_bit_d;
   logic              b_bit_q, b_bit_d;
   logic              cin_bit_q, cin_bit_d;
   logic              fs_q, fs_d;
   logic              bv_q, bv_d;
   logic              lb_q, lb_d;
   logic              in_ready_w;
   logic              accept;
   logic              do_load;

   // Ready in IDLE, or on the last bit of a frame when frames may run back-to-back
   always_comb begin
      in_ready_w = 1'b0;
      if (clr) begin
         if (state_q == S_IDLE) begin
            in_ready_w = 1'b1;
         end else if (B2B && state_q == S_SHIFT && cnt_q == LAST) begin
            in_ready_w = 1'b1;
         end
      end
   end

   assign accept = in_ready_w & bus.in_valid;

   // Next-state: the counter tracks the bit currently on the outputs, so
   // outputs for the following cycle are computed here and registered
   always_comb begin
      state_d   = state_q;
      a_sh_d    = a_sh_q;
      b_sh_d    = b_sh_q;
      cnt_d     = cnt_q;
      gap_d     = gap_q;
      fc_d      = fc_q;
      a_bit_d   = 1'b0;
      b_bit_d   = 1'b0;
      cin_bit_d = 1'b0;
      fs_d      = 1'b0;
      bv_d      = 1'b0;
      lb_d      = 1'b0;
      do_load   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               do_load = 1'b1;
            end
         end
         S_SHIFT: begin
            if (cnt_q == LAST) begin
               fc_d = fc_q + 8'd1;
               if (!B2B) begin
                  state_d = S_GAP;
                  gap_d   = 4'd0;
               end else if (accept) begin
                  do_load = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               a_bit_d = a_sh_q[0];
               b_bit_d = b_sh_q[0];
               a_sh_d  = a_sh_q >> 1;
               b_sh_d  = b_sh_q >> 1;
               cnt_d   = cnt_q + 1'b1;
               bv_d    = 1'b1;
               lb_d    = (cnt_q == PENULT);
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q + 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Bit 0 goes straight to the output register; the rest waits in the shifters
      if (do_load) begin
         state_d   = S_SHIFT;
         a_bit_d   = bus.a_word[0];
         b_bit_d   = bus.b_word[0];
         a_sh_d    = bus.a_word >> 1;
         b_sh_d    = bus.b_word >> 1;
         cin_bit_d = bus.cin;
         cnt_d     = '0;
         fs_d      = 1'b1;
         bv_d      = 1'b1;
         lb_d      = 1'b0;
      end
   end

   // State and registered outputs; reset discards any partial frame
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q   <= S_IDLE;
         a_sh_q    <= '0;
         b_sh_q    <= '0;
         cnt_q     <= '0;
         gap_q     <= '0;
         fc_q      <= '0;
         a_bit_q   <= 1'b0;
         b_bit_q   <= 1'b0;
         cin_bit_q <= 1'b0;
         fs_q      <= 1'b0;
         bv_q      <= 1'b0;
         lb_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_sh_q    <= a_sh_d;
         b_sh_q    <= b_sh_d;
         cnt_q     <= cnt_d;
         gap_q     <= gap_d;
         fc_q      <= fc_d;
         a_bit_q   <= a_bit_d;
         b_bit_q   <= b_bit_d;
         cin_bit_q <= cin_bit_d;
         fs_q      <= fs_d;
         bv_q      <= bv_d;
         lb_q      <= lb_d;
      end
   end

   assign bus.in_ready    = in_ready_w;
   assign bus.a_bit       = a_bit_q;
   assign bus.b_bit       = b_bit_q;
   assign bus.cin_bit     = cin_bit_q;
   assign bus.frame_start = fs_q;
   assign bus.bit_valid   = bv_q;
   assign bus.last_bit    = lb_q;
   assign bus.frame_count = fc_q;
endmodule
